// File: rtl/ising_pkg.sv
// Shared definitions for the Ising run controller: weight encoding, FSM states, legality check.
package ising_pkg;

    localparam int WEIGHT_W = 3;

    localparam logic [WEIGHT_W-1:0] W_NEG2 = 3'b000;
    localparam logic [WEIGHT_W-1:0] W_NEG1 = 3'b001;
    localparam logic [WEIGHT_W-1:0] W_ZERO = 3'b010;
    localparam logic [WEIGHT_W-1:0] W_POS1 = 3'b011;
    localparam logic [WEIGHT_W-1:0] W_POS2 = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SAMPLE = 2'd2
    } run_state_e;

    // Codes 101..111 have no meaning to the oscillator coupling network.
    function automatic logic weight_legal(input logic [WEIGHT_W-1:0] code);
        return code <= W_POS2;
    endfunction

endpackage

// File: rtl/ising_run_controller_phase_sync.sv
// Free-running two-flop synchronizer for the asynchronous oscillator phase outputs.
module phase_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ising_run_controller.sv
// Loads the coupling matrix, releases the oscillator array for a set number of cycles,
// then majority-votes three synchronized samples into a spin vector relative to oscillator 0.
module ising_run_controller
    import ising_pkg::*;
#(
    parameter int N     = 4,
    parameter int RUN_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    // Weight port: a write transfers on every cycle where wt_valid && wt_ready;
    // wt_ready is high exactly when no solve is in progress and rst is low.
    input  logic                        wt_valid,
    output logic                        wt_ready,
    input  logic [$clog2(N*N)-1:0]      wt_addr,
    input  logic [WEIGHT_W-1:0]         wt_data,
    input  logic                        start,
    input  logic                        abort,
    input  logic [RUN_W-1:0]            run_cycles,
    output logic [N*N*WEIGHT_W-1:0]     weights,
    output logic                        osc_en,
    input  logic [N-1:0]                osc_phase,
    output logic                        busy,
    output logic [N-1:0]                result,
    output logic                        result_valid,
    output logic                        err
);

    localparam int unsigned ENTRIES = N * N;

    run_state_e                              state;
    logic [RUN_W-1:0]                        count;
    logic [1:0]                              samp_idx;
    logic [N-1:0]                            samp0;
    logic [N-1:0]                            samp1;
    logic [N-1:0]                            sync_q;
    logic [N-1:0]                            vote;
    logic [ENTRIES-1:0][WEIGHT_W-1:0]        wt_mem;
    logic [31:0]                             addr_i;
    logic                                    wr_fire;
    logic                                    wr_ok;

    phase_sync #(.WIDTH(N)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (osc_phase),
        .q   (sync_q)
    );

    assign weights  = wt_mem;
    assign wt_ready = !busy && !rst;

    // Diagonal entries i*N+i are exactly the multiples of N+1 below N*N.
    always_comb begin
        addr_i  = 32'(wt_addr);
        wr_fire = wt_valid && wt_ready;
        wr_ok   = weight_legal(wt_data)
                  && (addr_i < ENTRIES)
                  && ((addr_i % 32'(N + 1)) != 32'd0);
        vote    = (samp0 & samp1) | (samp0 & sync_q) | (samp1 & sync_q);
    end

    always_ff @(posedge clk) begin
        result_valid <= 1'b0;
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            samp_idx <= '0;
            samp0    <= '0;
            samp1    <= '0;
            osc_en   <= 1'b0;
            busy     <= 1'b0;
            result   <= '0;
            err      <= 1'b0;
            for (int k = 0; k < int'(ENTRIES); k++) begin
                wt_mem[k] <= W_ZERO;
            end
        end else begin
            if (wr_fire) begin
                if (wr_ok) begin
                    wt_mem[wt_addr] <= wt_data;
                end else begin
                    err <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        count    <= (run_cycles == '0) ? RUN_W'(1) : run_cycles;
                        samp_idx <= '0;
                        osc_en   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        osc_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (count == RUN_W'(1)) begin
                        state    <= SAMPLE;
                        samp_idx <= '0;
                    end else begin
                        count <= count - RUN_W'(1);
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state  <= IDLE;
                        osc_en <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        case (samp_idx)
                            2'd0: begin
                                samp0    <= sync_q;
                                samp_idx <= 2'd1;
                            end
                            2'd1: begin
                                samp1    <= sync_q;
                                samp_idx <= 2'd2;
                            end
                            default: begin
                                // Third sample is voted straight from the synchronizer output.
                                result       <= vote ^ {N{vote[0]}};
                                result_valid <= 1'b1;
                                state        <= IDLE;
                                osc_en       <= 1'b0;
                                busy         <= 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    state  <= IDLE;
                    osc_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ising_run_controller.sv
// Self-checking bench for ising_run_controller: weight loading, solve timing, voting, aborts, reset.
`timescale 1ns/1ps
module tb_ising_run_controller;
    import ising_pkg::*;

    localparam int N       = 4;
    localparam int RUN_W   = 16;
    localparam int ENTRIES = N * N;
    localparam int AW      = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wt_valid;
    logic                    wt_ready;
    logic [AW-1:0]           wt_addr;
    logic [2:0]              wt_data;
    logic                    start;
    logic                    abort;
    logic [RUN_W-1:0]        run_cycles;
    logic [ENTRIES*3-1:0]    weights;
    logic                    osc_en;
    logic [N-1:0]            osc_phase;
    logic                    busy;
    logic [N-1:0]            result;
    logic                    result_valid;
    logic                    err;

    int compared   = 0;
    int mismatched = 0;

    logic [N-1:0] exp_q[$];
    logic [2:0]   exp_w[ENTRIES];
    logic         exp_err;
    logic [N-1:0] last_result;
    logic [N-1:0] cur_phase;
    logic [N-1:0] mon_exp;

    ising_run_controller #(.N(N), .RUN_W(RUN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .wt_valid     (wt_valid),
        .wt_ready     (wt_ready),
        .wt_addr      (wt_addr),
        .wt_data      (wt_data),
        .start        (start),
        .abort        (abort),
        .run_cycles   (run_cycles),
        .weights      (weights),
        .osc_en       (osc_en),
        .osc_phase    (osc_phase),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model helpers
    function automatic logic [ENTRIES*3-1:0] flat();
        logic [ENTRIES*3-1:0] f;
        f = '0;
        for (int k = 0; k < ENTRIES; k++) f[3*k +: 3] = exp_w[k];
        return f;
    endfunction

    function automatic logic [N-1:0] model_result(input logic [N-1:0] ph);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ph[i] ^ ph[0];
        return r;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < ENTRIES; k++) exp_w[k] = W_ZERO;
        exp_err     = 1'b0;
        last_result = '0;
    endtask

    // scoreboard: every result_valid pops one expected spin vector
    always @(posedge clk) begin
        #1;
        if (rst !== 1'b1 && result_valid === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_result_valid: got result=%b with nothing expected", result);
            end else begin
                mon_exp     = exp_q.pop_front();
                last_result = mon_exp;
                if (result !== mon_exp) begin
                    mismatched++;
                    $display("FAIL result_vector: got %b want %b", result, mon_exp);
                end
            end
        end
    end

    // drivers
    task automatic set_phase(input logic [N-1:0] ph);
        osc_phase = ph;
        cur_phase = ph;
        tick(); tick(); tick();
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (osc_en === 1'b1 && n < lim) begin
            n++;
            tick();
        end
    endtask

    task automatic write_wt(input int addr, input logic [2:0] data);
        logic legal;
        wt_valid = 1'b1;
        wt_addr  = addr[AW-1:0];
        wt_data  = data;
        #1;
        compared++;
        if (wt_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL wt_ready_handshake: got %b want 1 (addr %0d)", wt_ready, addr);
        end
        legal = (data <= 3'b100) && (addr < ENTRIES) && ((addr / N) != (addr % N));
        tick();
        wt_valid = 1'b0;
        if (legal) exp_w[addr] = data;
        else exp_err = 1'b1;
        compared++;
        if (weights !== flat()) begin
            mismatched++;
            $display("FAIL weights_after_write: got %h want %h (addr %0d)", weights, flat(), addr);
        end
        compared++;
        if (err !== exp_err) begin
            mismatched++;
            $display("FAIL err_after_write: got %b want %b (addr %0d data %b)", err, exp_err, addr, data);
        end
    endtask

    // poke>0 pulses start again (while busy) once that many enabled cycles have passed
    task automatic run_solve(input int r, input logic [N-1:0] ph, input int poke);
        int   reff;
        int   en_cycles;
        logic bad;
        reff       = (r == 0) ? 1 : r;
        run_cycles = r[RUN_W-1:0];
        start      = 1'b1;
        exp_q.push_back(model_result(ph));
        tick();
        start     = 1'b0;
        en_cycles = 0;
        bad       = 1'b0;
        while (osc_en === 1'b1 && en_cycles < reff + 10) begin
            if (busy !== 1'b1 || wt_ready !== 1'b0) bad = 1'b1;
            en_cycles++;
            start      = (en_cycles == poke);
            run_cycles = 16'd1;
            tick();
        end
        start = 1'b0;
        compared++;
        if (en_cycles != reff + 3) begin
            mismatched++;
            $display("FAIL osc_en_cycles: got %0d want %0d (R=%0d)", en_cycles, reff + 3, r);
        end
        compared++;
        if (bad) begin
            mismatched++;
            $display("FAIL busy_during_run: busy/wt_ready wrong while osc_en high (R=%0d)", r);
        end
        compared++;
        if (result_valid !== 1'b1 || busy !== 1'b0 || wt_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL end_of_run: got rv=%b busy=%b wt_ready=%b want 1 0 1", result_valid, busy, wt_ready);
        end
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b1; wt_valid = 1'b0; wt_addr = '0; wt_data = W_ZERO;
        start = 1'b0; abort = 1'b0; run_cycles = '0;
        osc_phase = '0; cur_phase = '0;
        reset_model();
        tick(); tick();
        compared++;
        if (wt_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL wt_ready_in_rst: got %b want 0", wt_ready);
        end
        rst = 1'b0;
        tick();
        compared++;
        if (weights !== flat()) begin
            mismatched++;
            $display("FAIL reset_weights: got %h want %h", weights, flat());
        end
        compared++;
        if ({osc_en, busy, wt_ready, result_valid, err} !== 5'b00100) begin
            mismatched++;
            $display("FAIL reset_controls: got en/busy/rdy/rv/err=%b want 00100",
                     {osc_en, busy, wt_ready, result_valid, err});
        end
        compared++;
        if (result !== '0) begin
            mismatched++;
            $display("FAIL reset_result: got %b want 0000", result);
        end
    endtask

    task automatic test_load_and_run();
        set_phase(4'b0101);
        write_wt(1, W_NEG2);
        write_wt(4, W_POS2);
        write_wt(7, W_NEG1);
        run_solve(5, 4'b0101, 0);
        tick();
        compared++;
        if (result_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL result_valid_pulse: got %b want 0 one cycle later", result_valid);
        end
    endtask

    task automatic test_inverted_phase();
        set_phase(4'b0110);
        run_solve(3, 4'b0110, 0);
        set_phase(4'b1001);
        run_solve(3, 4'b1001, 0);
    endtask

    // bit 2 driven high for glen cycles starting in cycle T+R so the synchronizer shows it from T+R+2
    task automatic test_majority(input int glen, input logic [N-1:0] voted);
        set_phase(4'b0011);
        run_cycles = 16'd4;
        start      = 1'b1;
        exp_q.push_back(model_result(voted));
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        osc_phase = 4'b0111;
        for (int g = 0; g < glen; g++) tick();
        osc_phase = 4'b0011;
        for (int g = glen; g < 4; g++) tick();
        compared++;
        if (result_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL majority_timing: got rv=%b want 1 (glitch %0d)", result_valid, glen);
        end
    endtask

    task automatic test_back_to_back();
        set_phase(4'b1100);
        run_solve(6, 4'b1100, 2);
        run_solve(2, 4'b1100, 0);
    endtask

    task automatic test_r_zero();
        set_phase(4'b1011);
        run_solve(0, 4'b1011, 0);
        run_solve(1, 4'b1011, 0);
    endtask

    task automatic test_illegal_writes();
        write_wt(2, 3'b101);
        write_wt(16, W_POS1);
        write_wt(5, W_NEG1);
        write_wt(3, 3'b111);
    endtask

    task automatic test_write_with_start();
        int n;
        wt_valid   = 1'b1;
        wt_addr    = 4'd6;
        wt_data    = W_POS1;
        start      = 1'b1;
        run_cycles = 16'd2;
        exp_q.push_back(model_result(cur_phase));
        tick();
        wt_valid = 1'b0;
        start    = 1'b0;
        exp_w[6] = W_POS1;
        compared++;
        if (weights !== flat() || osc_en !== 1'b1) begin
            mismatched++;
            $display("FAIL write_with_start: got en=%b weights=%h want 1 %h", osc_en, weights, flat());
        end
        wait_idle(20, n);
        compared++;
        if (n != 5 || result_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL write_with_start_run: got %0d cycles rv=%b want 5 1", n, result_valid);
        end
    endtask

    task automatic test_abort(input int r, input int at);
        logic saw_rv;
        run_cycles = r[RUN_W-1:0];
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < at; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        compared++;
        if ({osc_en, busy, wt_ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL abort_stop: got en/busy/rdy=%b want 001 (R=%0d at T+%0d)", {osc_en, busy, wt_ready}, r, at);
        end
        saw_rv = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (result_valid === 1'b1) saw_rv = 1'b1;
            tick();
        end
        compared++;
        if (saw_rv || result !== last_result) begin
            mismatched++;
            $display("FAIL abort_no_result: got rv_seen=%b result=%b want 0 %b", saw_rv, result, last_result);
        end
    endtask

    task automatic test_abort_idle();
        int n;
        abort      = 1'b1;
        start      = 1'b1;
        run_cycles = 16'd2;
        exp_q.push_back(model_result(cur_phase));
        tick();
        abort = 1'b0;
        start = 1'b0;
        wait_idle(20, n);
        compared++;
        if (n != 5 || result_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_in_idle: got %0d cycles rv=%b want 5 1", n, result_valid);
        end
    endtask

    task automatic test_rst_mid_sample();
        run_cycles = 16'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        reset_model();
        compared++;
        if (weights !== flat() || err !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_weights: got err=%b weights=%h want 0 %h", err, weights, flat());
        end
        compared++;
        if ({osc_en, busy, wt_ready, result_valid} !== 4'b0000 || result !== '0) begin
            mismatched++;
            $display("FAIL rst_mid_controls: got en/busy/rdy/rv=%b result=%b want 0000 0000",
                     {osc_en, busy, wt_ready, result_valid}, result);
        end
        rst = 1'b0;
        tick();
        compared++;
        if (wt_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_release: got rdy=%b busy=%b want 1 0", wt_ready, busy);
        end
    endtask

    // sequence and report
    initial begin
        test_reset();
        test_load_and_run();
        test_inverted_phase();
        test_majority(1, 4'b0011);
        test_majority(2, 4'b0111);
        test_back_to_back();
        test_r_zero();
        test_illegal_writes();
        test_write_with_start();
        set_phase(4'b1110);
        test_abort(5, 3);
        test_abort(2, 4);
        test_abort_idle();
        test_rst_mid_sample();
        tick(); tick();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d results outstanding want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
